// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM encodings, master ids, default timeout.
package bus_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational two-way round-robin picker: a lone request wins outright,
// a tie goes to the master that was not granted last.
module arb_rr_pick
  import bus_defs::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = M0;
    case (req)
      2'b01:   gnt_id = M0;
      2'b10:   gnt_id = M1;
      2'b11:   gnt_id = ~last_grant;
      default: gnt_id = M0;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one bridge bus port between two masters with round-robin grant and slave timeout.
// Zero-wait access: req sampled in IDLE at t, bus phase at t+1, one-cycle ack at t+2.
module bus_arbiter
  import bus_defs::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,

  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_wen,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_err,

  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_wen,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_err,

  output logic [ADDR_W-1:0] Bus_addr,
  output logic              Bus_wen,
  output logic [DATA_W-1:0] Bus_wdata,
  input  logic [DATA_W-1:0] Bus_rdata,
  input  logic              Bus_ready
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic              gid_q, gid_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic gnt_valid;
  logic gnt_id;

  arb_rr_pick u_pick (
    .req        ({m1_req, m0_req}),
    .last_grant (last_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    state_d    = state_q;
    gid_d      = gid_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          gid_d   = gnt_id;
          addr_d  = (gnt_id == M1) ? m1_addr  : m0_addr;
          wen_d   = (gnt_id == M1) ? m1_wen   : m0_wen;
          wdata_d = (gnt_id == M1) ? m1_wdata : m0_wdata;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (Bus_ready) begin
          if (gid_q == M1) m1_rdata_d = Bus_rdata;
          else             m0_rdata_d = Bus_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          // Dead slave: return zero data flagged as an error so the master unblocks.
          if (gid_q == M1) m1_rdata_d = '0;
          else             m0_rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        last_d  = gid_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q    <= IDLE;
      gid_q      <= M0;
      last_q     <= M1;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      gid_q      <= gid_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // The bus only ever sees the latched request, and only while BUSY.
  assign Bus_addr  = (state_q == BUSY) ? addr_q  : '0;
  assign Bus_wen   = (state_q == BUSY) ? wen_q   : 1'b0;
  assign Bus_wdata = (state_q == BUSY) ? wdata_q : '0;

  assign m0_ack   = (state_q == RESP) && (gid_q == M0);
  assign m1_ack   = (state_q == RESP) && (gid_q == M1);
  assign m0_err   = m0_ack & err_q;
  assign m1_err   = m1_ack & err_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected completions are queued as requests are issued
// and retired against each ack; bus phases and ack timing are checked cycle by cycle.
module tb_bus_arbiter;

  localparam int TO = 15;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        m0_req, m0_wen, m0_ack, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_wen, m1_ack, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [31:0] Bus_addr, Bus_wdata, Bus_rdata;
  logic        Bus_wen, Bus_ready;

  typedef struct packed {
    logic        id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_rd[2];
  int          total = 0;
  int          bad   = 0;

  always #5 cpu_clk = ~cpu_clk;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .m0_req    (m0_req),
    .m0_addr   (m0_addr),
    .m0_wen    (m0_wen),
    .m0_wdata  (m0_wdata),
    .m0_rdata  (m0_rdata),
    .m0_ack    (m0_ack),
    .m0_err    (m0_err),
    .m1_req    (m1_req),
    .m1_addr   (m1_addr),
    .m1_wen    (m1_wen),
    .m1_wdata  (m1_wdata),
    .m1_rdata  (m1_rdata),
    .m1_ack    (m1_ack),
    .m1_err    (m1_err),
    .Bus_addr  (Bus_addr),
    .Bus_wen   (Bus_wen),
    .Bus_wdata (Bus_wdata),
    .Bus_rdata (Bus_rdata),
    .Bus_ready (Bus_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Retire one scoreboard entry per completion pulse.
  always @(negedge cpu_clk) begin
    exp_t e;
    if (m0_ack && m1_ack) begin
      chk("dual_ack", {m1_ack, m0_ack}, 2'b01);
    end else if (m0_ack || m1_ack) begin
      if (sb.size() == 0) begin
        chk("spurious_ack", {m1_ack, m0_ack}, 2'b00);
      end else begin
        e = sb.pop_front();
        chk("sb_id", m1_ack, e.id);
        chk("sb_rdata", m1_ack ? m1_rdata : m0_rdata, e.rdata);
        chk("sb_err", m1_ack ? m1_err : m0_err, e.err);
      end
    end
  end

  // Entered one cycle after the grant edge (first BUSY cycle); returns in the RESP cycle.
  task automatic run_phase(input logic id, input logic [31:0] addr, input logic wen,
                           input logic [31:0] wdata, input int waits,
                           input logic [31:0] rdata, input logic to);
    int n;
    n = to ? TO : waits + 1;
    sb.push_back('{id: id, rdata: (to ? 32'h0 : rdata), err: to});
    for (int i = 0; i < n; i++) begin
      Bus_ready = !to && (i == n - 1);
      Bus_rdata = (i == n - 1) ? rdata : (32'hDEAD_0000 + 32'(i));
      @(negedge cpu_clk);
      chk("bus_addr", Bus_addr, addr);
      chk("bus_wen", Bus_wen, wen);
      chk("bus_wdata", Bus_wdata, wdata);
      chk("early_ack", {m1_ack, m0_ack}, 2'b00);
      @(posedge cpu_clk); #1;
    end
    Bus_ready = 1'b0;
    Bus_rdata = 32'hFFFF_FFFF;
    @(negedge cpu_clk);
    chk("ack_timing", id ? m1_ack : m0_ack, 1'b1);
    chk("other_ack", id ? m0_ack : m1_ack, 1'b0);
    chk("resp_wen", Bus_wen, 1'b0);
    chk("resp_addr", Bus_addr, 32'h0);
    exp_rd[id] = to ? 32'h0 : rdata;
    chk("hold_rdata", id ? m0_rdata : m1_rdata, exp_rd[~id]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    cpu_rst = 1'b1;
    m0_req = 0; m0_addr = 0; m0_wen = 0; m0_wdata = 0;
    m1_req = 0; m1_addr = 0; m1_wen = 0; m1_wdata = 0;
    Bus_rdata = 0; Bus_ready = 0;
    exp_rd[0] = 0; exp_rd[1] = 0;
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    chk("rst_wen", Bus_wen, 1'b0);
    chk("rst_addr", Bus_addr, 32'h0);
    chk("rst_wdata", Bus_wdata, 32'h0);
    chk("rst_acks", {m1_ack, m0_ack, m1_err, m0_err}, 4'h0);
    chk("rst_rdata0", m0_rdata, 32'h0);
    chk("rst_rdata1", m1_rdata, 32'h0);
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b0;

    // zero-wait read from master 0
    m0_req = 1; m0_addr = 32'h0001_0000; m0_wen = 0; m0_wdata = 32'h1111_1111;
    @(posedge cpu_clk); #1;
    run_phase(1'b0, 32'h0001_0000, 1'b0, 32'h1111_1111, 0, 32'h1234_5678, 1'b0);
    @(posedge cpu_clk); #1;
    m0_req = 0;

    // master 1 write with three wait states
    m1_req = 1; m1_addr = 32'h4; m1_wen = 1; m1_wdata = 32'hCAFE_F00D;
    @(posedge cpu_clk); #1;
    run_phase(1'b1, 32'h4, 1'b1, 32'hCAFE_F00D, 3, 32'hA5A5_5A5A, 1'b0);
    @(posedge cpu_clk); #1;
    m1_req = 0;

    // both masters requesting continuously: grants must alternate starting with m0
    m0_addr = 32'h100; m0_wen = 0; m0_wdata = 32'h0000_0A0A;
    m1_addr = 32'h200; m1_wen = 1; m1_wdata = 32'h0000_0B0B;
    m0_req = 1; m1_req = 1;
    @(posedge cpu_clk); #1;
    for (int k = 0; k < 4; k++) begin
      logic pick;
      pick = (k % 2) == 1;
      run_phase(pick, pick ? 32'h200 : 32'h100, pick, pick ? 32'h0B0B : 32'h0A0A,
                0, 32'h1000 + 32'(k), 1'b0);
      @(posedge cpu_clk); #1;
      if (k == 3) begin
        m0_req = 0; m1_req = 0;
      end else begin
        @(posedge cpu_clk); #1;
      end
    end

    // slave never answers: exactly TO busy cycles, then error completion
    m0_req = 1; m0_addr = 32'h300; m0_wen = 0; m0_wdata = 32'h3333;
    @(posedge cpu_clk); #1;
    run_phase(1'b0, 32'h300, 1'b0, 32'h3333, 0, 32'h7777_7777, 1'b1);
    @(posedge cpu_clk); #1;
    m0_addr = 32'h304;
    @(posedge cpu_clk); #1;
    run_phase(1'b0, 32'h304, 1'b0, 32'h3333, 1, 32'h5555_AAAA, 1'b0);
    @(posedge cpu_clk); #1;
    m0_req = 0;

    // reset in the second busy cycle of a master 1 write
    m1_req = 1; m1_addr = 32'h8; m1_wen = 1; m1_wdata = 32'h0000_BEEF;
    @(posedge cpu_clk); #1;
    @(posedge cpu_clk); #1;
    @(negedge cpu_clk);
    chk("pre_rst_wen", Bus_wen, 1'b1);
    cpu_rst = 1; m0_addr = 32'h500; m0_wdata = 32'h5050;
    @(posedge cpu_clk); #1;
    cpu_rst = 0; m0_req = 1;
    exp_rd[0] = 0; exp_rd[1] = 0;
    @(negedge cpu_clk);
    chk("mid_rst_wen", Bus_wen, 1'b0);
    chk("mid_rst_ack", {m1_ack, m0_ack}, 2'b00);
    chk("mid_rst_rdata1", m1_rdata, 32'h0);
    @(posedge cpu_clk); #1;
    run_phase(1'b0, 32'h500, 1'b0, 32'h5050, 0, 32'h0BAD_CAFE, 1'b0);
    @(posedge cpu_clk); #1;
    m0_req = 0;
    @(posedge cpu_clk); #1;
    run_phase(1'b1, 32'h8, 1'b1, 32'h0000_BEEF, 0, 32'h0000_0808, 1'b0);
    @(posedge cpu_clk); #1;
    m1_req = 0;

    // stray Bus_ready while idle, then master 0 changes its address mid-access
    Bus_ready = 1; Bus_rdata = 32'h9999_9999;
    for (int i = 0; i < 3; i++) begin
      @(negedge cpu_clk);
      chk("idle_ready_ack", {m1_ack, m0_ack}, 2'b00);
      chk("idle_ready_wen", Bus_wen, 1'b0);
      @(posedge cpu_clk); #1;
    end
    Bus_ready = 0;
    m0_req = 1; m0_addr = 32'h600; m0_wen = 0; m0_wdata = 32'h6060;
    @(posedge cpu_clk); #1;
    m0_addr = 32'h0000_BAD0; m0_wdata = 32'hFFFF_0000; m0_wen = 1;
    run_phase(1'b0, 32'h600, 1'b0, 32'h6060, 2, 32'h6666_0000, 1'b0);
    @(posedge cpu_clk); #1;
    m0_req = 0;

    repeat (3) @(posedge cpu_clk);
    #1;
    chk("sb_empty", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
